// File: rtl/hrbridge_flit_fifo_pkg.sv
// Shared definitions for the hierarchical-ring bridge flit FIFOs.
//   CONTROL_W    : flit width (valid bit + destination + payload)
//   VALID_F      : bit index of the flit valid bit
//   DEST_HI/LO   : destination field range
//   HR_BUF_DEPTH : default FIFO depth used by the bridge instantiations
package hrbridge_flit_fifo_pkg;

  localparam int unsigned CONTROL_W    = 16;
  localparam int unsigned CONTROL_N    = CONTROL_W - 1;
  localparam int unsigned VALID_F      = CONTROL_W - 1;
  localparam int unsigned DEST_HI      = CONTROL_W - 2;
  localparam int unsigned DEST_LO      = CONTROL_W - 4;
  localparam int unsigned HR_BUF_DEPTH = 4;

  typedef logic [CONTROL_W-1:0] flit_t;

  // Occupancy update from the two accepted strobes.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'b00,
    OCC_DEC  = 2'b01,
    OCC_INC  = 2'b10,
    OCC_SWAP = 2'b11
  } occ_op_e;

endpackage

// File: rtl/hrbridge_fifo_ptr.sv
// Wrapping FIFO pointer with an increment enable.
//   clk   : clock
//   rst_n : asynchronous active-low reset, pointer returns to 0
//   inc_i : advance pointer by one at the next rising edge
//   ptr_o : current pointer (wraps naturally at 2**W)
module hrbridge_fifo_ptr #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/hrbridge_flit_fifo.sv
// Per-port flit buffer on the far side of the hierarchical-ring bridge FIFO
// interface. First-word fall-through; all outputs decode from registers only.
//   clk     : bridge clock
//   rst_n   : asynchronous active-low reset
//   FIFO_i  : flit from bridge          enQ_i : enqueue strobe
//   deQ_i   : dequeue strobe            FIFO_o: head flit (0 when empty)
//   bfull_o : buffer full               empty_o: buffer empty
//   count_o : occupancy
// Optional (macro HRBRIDGE_FIFO_STATS_EN):
//   hwm_o   : sticky max occupancy      ovf_o : sticky enqueue-while-full
//   udf_o   : sticky dequeue-while-empty
module hrbridge_flit_fifo
  import hrbridge_flit_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = HR_BUF_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CONTROL_W-1:0] FIFO_i,
  input  logic                 enQ_i,
  input  logic                 deQ_i,
  output logic [CONTROL_W-1:0] FIFO_o,
  output logic                 bfull_o,
  output logic                 empty_o,
  output logic [PTR_W:0]       count_o
`ifdef HRBRIDGE_FIFO_STATS_EN
  ,
  output logic [PTR_W:0]       hwm_o,
  output logic                 ovf_o,
  output logic                 udf_o
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [CONTROL_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [PTR_W:0]       count_q, count_d;
  logic                 full, empty, do_enq, do_deq;
  occ_op_e              occ_op;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Enqueue at full is accepted only when the head leaves in the same cycle.
  assign do_deq = deQ_i & ~empty;
  assign do_enq = enQ_i & (~full | do_deq);
  assign occ_op = occ_op_e'({do_enq, do_deq});

  always_comb begin
    count_d = count_q;
    unique case (occ_op)
      OCC_INC:  count_d = count_q + (PTR_W+1)'(1);
      OCC_DEC:  count_d = count_q - (PTR_W+1)'(1);
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  hrbridge_fifo_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (do_deq),
    .ptr_o (rd_ptr)
  );

  hrbridge_fifo_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (do_enq),
    .ptr_o (wr_ptr)
  );

  // Storage is not reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr] <= FIFO_i;
  end

  assign FIFO_o  = empty ? '0 : mem_q[rd_ptr];
  assign bfull_o = full;
  assign empty_o = empty;
  assign count_o = count_q;

`ifdef HRBRIDGE_FIFO_STATS_EN
  logic [PTR_W:0] hwm_q;
  logic           ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (count_d > hwm_q)          hwm_q <= count_d;
      if (full & enQ_i & ~deQ_i)    ovf_q <= 1'b1;
      if (empty & deQ_i)            udf_q <= 1'b1;
    end
  end

  assign hwm_o = hwm_q;
  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

endmodule

// File: tb/tb_hrbridge_flit_fifo.sv
module tb_hrbridge_flit_fifo;
  import hrbridge_flit_fifo_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [CONTROL_W-1:0] FIFO_i = '0;
  logic                 enQ_i = 1'b0;
  logic                 deQ_i = 1'b0;
  logic [CONTROL_W-1:0] FIFO_o;
  logic                 bfull_o, empty_o;
  logic [PTR_W:0]       count_o;
`ifdef HRBRIDGE_FIFO_STATS_EN
  logic [PTR_W:0]       hwm_o;
  logic                 ovf_o, udf_o;
`endif

  hrbridge_flit_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .FIFO_i  (FIFO_i),
    .enQ_i   (enQ_i),
    .deQ_i   (deQ_i),
    .FIFO_o  (FIFO_o),
    .bfull_o (bfull_o),
    .empty_o (empty_o),
    .count_o (count_o)
`ifdef HRBRIDGE_FIFO_STATS_EN
    ,
    .hwm_o   (hwm_o),
    .ovf_o   (ovf_o),
    .udf_o   (udf_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of flits the model expects the FIFO to hold, head first.
  logic [CONTROL_W-1:0] sb_q [$];
  int unsigned          m_hwm = 0;
  bit                   m_ovf = 0, m_udf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [31:0] head;
    head = (sb_q.size() > 0) ? 32'(sb_q[0]) : 32'h0;
    chk({tag, ".count"}, 32'(count_o), 32'(sb_q.size()));
    chk({tag, ".full"},  32'(bfull_o), 32'(sb_q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty_o), 32'(sb_q.size() == 0));
    chk({tag, ".head"},  32'(FIFO_o),  head);
`ifdef HRBRIDGE_FIFO_STATS_EN
    chk({tag, ".hwm"}, 32'(hwm_o), 32'(m_hwm));
    chk({tag, ".ovf"}, 32'(ovf_o), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(udf_o), 32'(m_udf));
`endif
  endtask

  // One clock cycle of stimulus, driven and checked at the falling edge.
  task automatic cycle(input string tag, input bit en, input bit de, input logic [CONTROL_W-1:0] d);
    bit popped;
    FIFO_i = d; enQ_i = en; deQ_i = de;
    popped = 0;
    if (en && !de && sb_q.size() == DEPTH) m_ovf = 1;
    if (de && sb_q.size() == 0) m_udf = 1;
    if (de && sb_q.size() > 0) begin
      chk({tag, ".deq"}, 32'(FIFO_o), 32'(sb_q[0]));
      void'(sb_q.pop_front());
      popped = 1;
    end
    if (en && (sb_q.size() < DEPTH || popped)) sb_q.push_back(d);
    if (sb_q.size() > m_hwm) m_hwm = sb_q.size();
    @(posedge clk);
    @(negedge clk);
    enQ_i = 0; deQ_i = 0; FIFO_i = '0;
    chk_state(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs checked before any edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    m_hwm = 0; m_ovf = 0; m_udf = 0;
    chk_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [CONTROL_W-1:0] flit(input int unsigned n);
    return {1'b1, CONTROL_N'(n * 37 + 5)};
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    async_reset("reset");
    repeat (2) cycle("idle", 0, 0, '0);

    // Fill A..D then drain in order.
    for (int i = 0; i < 4; i++) cycle("fill", 1, 0, flit(i));
    for (int i = 0; i < 4; i++) cycle("drain", 0, 1, '0);

    // Swap at full.
    for (int i = 0; i < 4; i++) cycle("fill2", 1, 0, flit(i));
    cycle("swap", 1, 1, flit(4));
    for (int i = 0; i < 4; i++) cycle("drain2", 0, 1, '0);

    // Overflow while full, underflow while empty.
    for (int i = 0; i < 4; i++) cycle("fill3", 1, 0, flit(10 + i));
    cycle("ovf", 1, 0, 16'hBEEF);
    for (int i = 0; i < 4; i++) cycle("drain3", 0, 1, '0);
    cycle("udf", 0, 1, '0);
    cycle("empty_enq_deq", 1, 1, flit(20));
    cycle("drain4", 0, 1, '0);

    // Wrap-around with occupancy held in 1..3 from a fresh reset.
    async_reset("reset2");
    cycle("wrap", 1, 0, flit(30));
    cycle("wrap", 1, 0, flit(31));
    cycle("wrap", 1, 1, flit(32));
    cycle("wrap", 1, 0, flit(33));
    cycle("wrap", 0, 1, '0);
    cycle("wrap", 1, 1, flit(34));
    cycle("wrap", 0, 1, '0);
    cycle("wrap", 1, 0, flit(35));
    cycle("wrap", 1, 1, flit(36));
    cycle("wrap", 0, 1, '0);
    while (sb_q.size() > 0) cycle("wrap_drain", 0, 1, '0);

    // Reset with three flits held.
    for (int i = 0; i < 3; i++) cycle("fill5", 1, 0, flit(40 + i));
    async_reset("reset_mid");
    cycle("post_reset", 1, 0, flit(50));
    cycle("post_reset_drain", 0, 1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
